spi_master: RTL and testbench
=============================

Name: spi_master

Overview:
- Host-side SPI master for the hashing ASIC serial link, in mode CPOL=1, CPHA=1.
- Transmits one FRAME_BITS-wide word MSB-first on mosi and, in the same frame, captures FRAME_BITS bits from miso.
- Generates sclk and cs_n from the system clock.
- Sits in the controller/FPGA, driving the ASIC's SPI slave port. It is the initiating end of that link.

Parameters:
- FRAME_BITS, 360, bits per frame; must equal the slave's shift length.
- DIV, 4, system clocks per sclk half-period; must be ≥1.

Ports:
- clk, input, 1, system clock; all logic on its rising edge.
- reset, input, 1, asynchronous active-high reset.
- start, input, 1, request a frame; sampled only when busy=0.
- tx_data, input, FRAME_BITS, word to send; latched on the start-accept cycle.
- busy, output, 1, high from the start-accept cycle through the end of GAP.
- done, output, 1, one-clk pulse when rx_data is updated.
- rx_data, output, FRAME_BITS, last completed received word; first received bit at [FRAME_BITS-1].
- cs_n, output, 1, chip select, active low.
- sclk, output, 1, serial clock; idles high.
- mosi, output, 1, serial data out; idles high.
- miso, input, 1, serial data in; treated as synchronous to sclk.

Behaviour:
- Reset (async, immediate): cs_n=1, sclk=1, mosi=1, busy=0, done=0, rx_data=0. State goes to IDLE and all counters clear.
- Reset mid-frame aborts the frame. cs_n rising resynchronises the slave; no done is produced.
- States: IDLE, SETUP, LOW, HIGH, HOLD, GAP.
- A half-period counter runs DIV clk cycles in every non-IDLE state. The state acts on the cycle the counter expires.
- IDLE, start=1:
  - Latch tx_data into the tx shift register.
  - cs_n<=0, busy<=1, bit_cnt<=0; go to SETUP.
- SETUP expiry:
  - sclk<=0 (falling edge).
  - mosi<=tx[FRAME_BITS-1]; go to LOW.
- LOW expiry:
  - sclk<=1 (rising edge).
  - Sample miso in this same clk cycle: rx_shift<={rx_shift[FRAME_BITS-2:0], miso}.
  - If bit_cnt==FRAME_BITS-1, go to HOLD. Otherwise bit_cnt++ and go to HIGH.
- HIGH expiry:
  - sclk<=0.
  - mosi<=next tx bit (MSB first); go to LOW.
- HOLD expiry (sclk stays high):
  - cs_n<=1, mosi<=1.
  - rx_data<=rx_shift, done<=1 for exactly this one cycle; go to GAP.
- GAP expiry: busy<=0; go to IDLE. The next start can be accepted on the following cycle.
- Frame timing:
  - cs_n is low for exactly DIV*(2*FRAME_BITS+1) clk cycles.
  - Exactly FRAME_BITS falling and FRAME_BITS rising sclk edges occur while cs_n=0.
  - No sclk edge occurs while cs_n=1.
- mosi changes only on sclk falling edges or at cs_n rise. It is held stable across each rising edge.
- start while busy=1 is ignored and is not queued. tx_data changes after accept do not affect the frame in flight.
- rx_data holds its value between frames and is unchanged by aborted frames.
- bit_cnt width is clog2(FRAME_BITS). The half-period counter width is clog2(DIV)+1. No wrap is possible within a legal frame.
- Loopback property: with the ASIC slave attached, the slave's mosi_data equals tx_data after the frame. rx_data equals the slave's miso_data as it stood during the frame.

Decomposition:
- Shared package spi_pkg holds:
  - FRAME_BITS=360 and DIV default.
  - CPOL=1 and CPHA=1 constants.
  - State enum (IDLE, SETUP, LOW, HIGH, HOLD, GAP).
  - Idle levels (sclk=1, mosi=1, cs_n=1).
- One sub-module, spi_half_tick: a loadable down-counter giving a one-cycle expiry pulse every DIV clocks, cleared by reset and in IDLE.

Test Plan:
- Single frame, DIV=4, slave model attached:
  - Stimulus: tx_data = 360'hA5 repeated; slave miso_data = 360'h3C repeated.
  - Expected: slave mosi_data = A5 pattern; rx_data = 3C pattern; done exactly once; cs_n low for 2884 clks.
- Edge audit:
  - Stimulus: tx_data = {1'b1, 359'b0}.
  - Expected: mosi=1 only during the first bit; 360 rising edges while cs_n=0; sclk=1 whenever cs_n=1.
- Back-to-back:
  - Stimulus: hold start=1 continuously with two different words.
  - Expected: second frame begins ≥DIV+1 clks after the first cs_n rise; two done pulses; rx_data updated each time.
- Start while busy:
  - Stimulus: pulse start at mid-frame with a new tx_data.
  - Expected: ignored; current frame's mosi bits unchanged; no extra frame afterwards.
- Reset mid-frame:
  - Stimulus: assert reset at bit 100.
  - Expected: cs_n=1, sclk=1, mosi=1, busy=0 in the same cycle (async); no done; rx_data=0; next frame completes correctly.
- DIV=1 corner:
  - Stimulus: all-ones tx_data; miso tied 0.
  - Expected: rx_data=0; cs_n low for 721 clks; sclk toggles every clk.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared constants for the hashing-ASIC SPI link: frame geometry, mode, FSM
// state encodings and pin idle levels.
package spi_pkg;

    localparam int unsigned SPI_FRAME_BITS = 360;
    localparam int unsigned SPI_DIV        = 4;

    localparam logic SPI_CPOL = 1'b1;
    localparam logic SPI_CPHA = 1'b1;

    localparam int unsigned ST_W = 3;
    typedef logic [ST_W-1:0] spi_state_t;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_SETUP = 3'd1;
    localparam logic [2:0] ST_LOW   = 3'd2;
    localparam logic [2:0] ST_HIGH  = 3'd3;
    localparam logic [2:0] ST_HOLD  = 3'd4;
    localparam logic [2:0] ST_GAP   = 3'd5;

    localparam logic SCLK_IDLE = SPI_CPOL;
    localparam logic MOSI_IDLE = 1'b1;
    localparam logic CS_N_IDLE = 1'b1;

endpackage

// File: rtl/spi_master_if.sv
// Host-side request/response bundle of the SPI master.
interface spi_master_if
    import spi_pkg::*;
#(
    parameter int unsigned FRAME_BITS = SPI_FRAME_BITS
);
    logic                  start;
    logic [FRAME_BITS-1:0] tx_data;
    logic                  busy;
    logic                  done;
    logic [FRAME_BITS-1:0] rx_data;

    // master: the controller issuing frames; slave: the spi_master block itself
    modport master (output start, output tx_data, input busy, input done, input rx_data);
    modport slave  (input start, input tx_data, output busy, output done, output rx_data);
endinterface

// File: rtl/spi_half_tick.sv
// Half-period timer: one-cycle expire_c pulse every DIV clocks while enabled;
// held at its reload value while disabled so each state lasts exactly DIV clocks.
module spi_half_tick #(
    parameter int unsigned DIV = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    output logic expire_c
);
    localparam int unsigned CW = $clog2(DIV) + 1;
    localparam logic [CW-1:0] RELOAD = CW'(DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d    = cnt_q;
        expire_c = 1'b0;
        if (!en) begin
            cnt_d = RELOAD;
        end else if (cnt_q == '0) begin
            expire_c = 1'b1;
            cnt_d    = RELOAD;
        end else begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end
endmodule

// File: rtl/spi_master.sv
// SPI master, CPOL=1/CPHA=1: shifts one FRAME_BITS word out MSB-first on mosi
// while capturing FRAME_BITS bits from miso; all pins driven from flops.
module spi_master
    import spi_pkg::*;
#(
    parameter int unsigned FRAME_BITS = SPI_FRAME_BITS,
    parameter int unsigned DIV        = SPI_DIV
) (
    input  logic         clk,
    input  logic         reset,
    spi_master_if.slave  host,
    output logic         cs_n,
    output logic         sclk,
    output logic         mosi,
    input  logic         miso
);
    localparam int unsigned BW = $clog2(FRAME_BITS);
    localparam logic [BW-1:0] LAST_BIT = BW'(FRAME_BITS - 1);

    spi_state_t            state_q, state_d;
    logic [FRAME_BITS-1:0] tx_q, tx_d;
    logic [FRAME_BITS-1:0] rx_q, rx_d;
    logic [FRAME_BITS-1:0] rx_data_q, rx_data_d;
    logic [BW-1:0]         bit_cnt_q, bit_cnt_d;
    logic                  cs_n_q, cs_n_d;
    logic                  sclk_q, sclk_d;
    logic                  mosi_q, mosi_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  expire_c;

    spi_half_tick #(.DIV(DIV)) u_half_tick (
        .clk      (clk),
        .reset    (reset),
        .en       (state_q != ST_IDLE),
        .expire_c (expire_c)
    );

    always_comb begin
        state_d   = state_q;
        tx_d      = tx_q;
        rx_d      = rx_q;
        rx_data_d = rx_data_q;
        bit_cnt_d = bit_cnt_q;
        cs_n_d    = cs_n_q;
        sclk_d    = sclk_q;
        mosi_d    = mosi_q;
        busy_d    = busy_q;
        done_d    = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (host.start) begin
                    tx_d      = host.tx_data;
                    cs_n_d    = 1'b0;
                    busy_d    = 1'b1;
                    bit_cnt_d = '0;
                    state_d   = ST_SETUP;
                end
            end
            // Falling edge: present the next bit and consume it from the shifter
            ST_SETUP, ST_HIGH: begin
                if (expire_c) begin
                    sclk_d  = 1'b0;
                    mosi_d  = tx_q[FRAME_BITS-1];
                    tx_d    = {tx_q[FRAME_BITS-2:0], 1'b0};
                    state_d = ST_LOW;
                end
            end
            ST_LOW: begin
                if (expire_c) begin
                    sclk_d = 1'b1;
                    rx_d   = {rx_q[FRAME_BITS-2:0], miso};
                    if (bit_cnt_q == LAST_BIT) begin
                        state_d = ST_HOLD;
                    end else begin
                        bit_cnt_d = bit_cnt_q + BW'(1);
                        state_d   = ST_HIGH;
                    end
                end
            end
            ST_HOLD: begin
                if (expire_c) begin
                    cs_n_d    = CS_N_IDLE;
                    mosi_d    = MOSI_IDLE;
                    rx_data_d = rx_q;
                    done_d    = 1'b1;
                    state_d   = ST_GAP;
                end
            end
            ST_GAP: begin
                if (expire_c) begin
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            tx_q      <= '0;
            rx_q      <= '0;
            rx_data_q <= '0;
            bit_cnt_q <= '0;
            cs_n_q    <= CS_N_IDLE;
            sclk_q    <= SCLK_IDLE;
            mosi_q    <= MOSI_IDLE;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            tx_q      <= tx_d;
            rx_q      <= rx_d;
            rx_data_q <= rx_data_d;
            bit_cnt_q <= bit_cnt_d;
            cs_n_q    <= cs_n_d;
            sclk_q    <= sclk_d;
            mosi_q    <= mosi_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign cs_n         = cs_n_q;
    assign sclk         = sclk_q;
    assign mosi         = mosi_q;
    assign host.busy    = busy_q;
    assign host.done    = done_q;
    assign host.rx_data = rx_data_q;
endmodule

// File: tb/tb_spi_master.sv
// Directed bench for spi_master: DIV=4 instance with a CPOL=1/CPHA=1 slave
// model, plus a DIV=1 instance with miso tied low.
module tb_spi_master;
    import spi_pkg::*;

    localparam int unsigned FB = 360;
    localparam logic [FB-1:0] ONE    = FB'(1);
    localparam logic [FB-1:0] ZERO   = '0;
    localparam logic [FB-1:0] W_A5   = {45{8'hA5}};
    localparam logic [FB-1:0] W_3C   = {45{8'h3C}};
    localparam logic [FB-1:0] W_TOP  = {1'b1, {(FB-1){1'b0}}};
    localparam logic [FB-1:0] W_B1   = {45{8'h96}};
    localparam logic [FB-1:0] W_B2   = {90{4'h1}};
    localparam logic [FB-1:0] M_B1   = {45{8'hF0}};
    localparam logic [FB-1:0] M_B2   = {45{8'h0F}};
    localparam logic [FB-1:0] W_S    = {45{8'hC3}};
    localparam logic [FB-1:0] M_S    = {45{8'h81}};
    localparam logic [FB-1:0] W_R    = {30{12'hABC}};
    localparam logic [FB-1:0] M_R    = {30{12'h123}};

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    spi_master_if #(.FRAME_BITS(FB)) h0 ();
    spi_master_if #(.FRAME_BITS(FB)) h1 ();

    logic cs_n0, sclk0, mosi0;
    logic cs_n1, sclk1, mosi1;
    logic s_miso = 1'b1;

    spi_master #(.FRAME_BITS(FB), .DIV(4)) u_dut0 (
        .clk(clk), .reset(reset), .host(h0),
        .cs_n(cs_n0), .sclk(sclk0), .mosi(mosi0), .miso(s_miso)
    );
    spi_master #(.FRAME_BITS(FB), .DIV(1)) u_dut1 (
        .clk(clk), .reset(reset), .host(h1),
        .cs_n(cs_n1), .sclk(sclk1), .mosi(mosi1), .miso(1'b0)
    );

    // Slave model: drives miso on falling sclk, samples mosi on rising sclk
    logic [FB-1:0] s_word = '0;
    logic [FB-1:0] s_rx   = '0;
    logic [FB-1:0] s_last = '0;
    int            s_idx  = 0;

    always @(negedge sclk0 or posedge cs_n0) begin
        if (cs_n0) begin
            s_idx  <= 0;
            s_miso <= 1'b1;
        end else begin
            s_miso <= s_word[FB-1-s_idx];
            s_idx  <= s_idx + 1;
        end
    end
    always @(posedge sclk0) if (!cs_n0) s_rx <= {s_rx[FB-2:0], mosi0};
    always @(posedge cs_n0) s_last <= s_rx;

    int   cyc, low0, rise0, fall0, bad_edge0, bad_idle0, mosi_bad0, mhi0, done0, csf0;
    int   last_rise_cyc, gap0;
    int   low1, tog1, mhi1, done1;
    logic p_sclk0 = 1'b1, p_cs0 = 1'b1, p_mosi0 = 1'b1, p_sclk1 = 1'b1;

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (!cs_n0) low0 <= low0 + 1;
        if (!cs_n0 && sclk0 && !p_sclk0) rise0 <= rise0 + 1;
        if (!cs_n0 && !sclk0 && p_sclk0) fall0 <= fall0 + 1;
        if (cs_n0 && p_cs0 && sclk0 !== p_sclk0) bad_edge0 <= bad_edge0 + 1;
        if (cs_n0 && !sclk0) bad_idle0 <= bad_idle0 + 1;
        if (mosi0 !== p_mosi0 && !(p_sclk0 && !sclk0) && !(cs_n0 && !p_cs0))
            mosi_bad0 <= mosi_bad0 + 1;
        if (!cs_n0 && mosi0) mhi0 <= mhi0 + 1;
        if (h0.done) done0 <= done0 + 1;
        if (cs_n0 && !p_cs0) last_rise_cyc <= cyc;
        if (!cs_n0 && p_cs0) begin
            gap0 <= cyc - last_rise_cyc;
            csf0 <= csf0 + 1;
        end
        if (!cs_n1) low1 <= low1 + 1;
        if (!cs_n1 && sclk1 !== p_sclk1) tog1 <= tog1 + 1;
        if (!cs_n1 && mosi1) mhi1 <= mhi1 + 1;
        if (h1.done) done1 <= done1 + 1;
        p_sclk0 <= sclk0;
        p_cs0   <= cs_n0;
        p_mosi0 <= mosi0;
        p_sclk1 <= sclk1;
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string tag, input logic [FB-1:0] got, input logic [FB-1:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_done0(output bit seen);
        seen = 1'b0;
        for (int i = 0; i < 8000 && !seen; i++) begin
            tick();
            if (h0.done) seen = 1'b1;
        end
    endtask

    task automatic wait_idle0();
        for (int i = 0; i < 100 && h0.busy; i++) tick();
    endtask

    task automatic run_frame0(input logic [FB-1:0] tx, input logic [FB-1:0] mw, output bit seen);
        s_word     = mw;
        h0.tx_data = tx;
        h0.start   = 1'b1;
        tick();
        h0.start   = 1'b0;
        wait_done0(seen);
        wait_idle0();
    endtask

    initial begin
        bit seen;
        int s_low, s_rise, s_fall, s_mhi, s_done, s_csf, s_tog;

        h0.start = 1'b0; h0.tx_data = '0;
        h1.start = 1'b0; h1.tx_data = '0;
        repeat (3) tick();
        chk("rst_cs_n", FB'(cs_n0), ONE);
        chk("rst_sclk", FB'(sclk0), ONE);
        chk("rst_mosi", FB'(mosi0), ONE);
        chk("rst_busy", FB'(h0.busy), ZERO);
        chk("rst_done", FB'(h0.done), ZERO);
        chk("rst_rx_data", h0.rx_data, ZERO);
        reset = 1'b0;
        tick();

        // Single frame, A5 out / 3C in
        s_low = low0; s_rise = rise0; s_fall = fall0; s_done = done0;
        run_frame0(W_A5, W_3C, seen);
        chk("f1_done_seen", FB'(seen), ONE);
        chk("f1_slave_rx", s_last, W_A5);
        chk("f1_rx_data", h0.rx_data, W_3C);
        chk("f1_done_count", FB'(done0 - s_done), FB'(1));
        chk("f1_cs_low_clks", FB'(low0 - s_low), FB'(2884));
        chk("f1_rises", FB'(rise0 - s_rise), FB'(360));
        chk("f1_falls", FB'(fall0 - s_fall), FB'(360));
        chk("f1_busy_after", FB'(h0.busy), ZERO);

        // Edge audit with only the MSB set
        s_rise = rise0; s_mhi = mhi0;
        run_frame0(W_TOP, W_A5, seen);
        chk("ea_done_seen", FB'(seen), ONE);
        chk("ea_slave_rx", s_last, W_TOP);
        chk("ea_mosi_hi_clks", FB'(mhi0 - s_mhi), FB'(12));
        chk("ea_rises", FB'(rise0 - s_rise), FB'(360));
        chk("ea_rx_data", h0.rx_data, W_A5);
        chk("ea_sclk_edge_cs_high", FB'(bad_edge0), ZERO);
        chk("ea_sclk_low_cs_high", FB'(bad_idle0), ZERO);
        chk("ea_mosi_bad_change", FB'(mosi_bad0), ZERO);

        // Back-to-back with start held high
        s_done = done0;
        s_word = M_B1; h0.tx_data = W_B1; h0.start = 1'b1;
        tick();
        chk("bb_busy_accept", FB'(h0.busy), ONE);
        h0.tx_data = W_B2;
        wait_done0(seen);
        chk("bb1_done_seen", FB'(seen), ONE);
        chk("bb1_slave_rx", s_last, W_B1);
        chk("bb1_rx_data", h0.rx_data, M_B1);
        s_word = M_B2;
        wait_done0(seen);
        h0.start = 1'b0;
        chk("bb2_done_seen", FB'(seen), ONE);
        chk("bb2_slave_rx", s_last, W_B2);
        chk("bb2_rx_data", h0.rx_data, M_B2);
        chk("bb_gap_clks", FB'(gap0), FB'(5));
        chk("bb_done_count", FB'(done0 - s_done), FB'(2));
        wait_idle0();

        // Start pulsed mid-frame must be ignored
        s_done = done0; s_csf = csf0;
        s_word = M_S; h0.tx_data = W_S; h0.start = 1'b1;
        tick();
        h0.start = 1'b0;
        repeat (1200) tick();
        h0.tx_data = ~W_S; h0.start = 1'b1;
        tick();
        h0.start = 1'b0;
        wait_done0(seen);
        chk("sb_done_seen", FB'(seen), ONE);
        chk("sb_slave_rx", s_last, W_S);
        chk("sb_rx_data", h0.rx_data, M_S);
        repeat (100) tick();
        chk("sb_busy_after", FB'(h0.busy), ZERO);
        chk("sb_frames", FB'(csf0 - s_csf), FB'(1));
        chk("sb_done_count", FB'(done0 - s_done), FB'(1));

        // Asynchronous reset at bit 100
        s_rise = rise0; s_done = done0;
        s_word = M_R; h0.tx_data = W_R; h0.start = 1'b1;
        tick();
        h0.start = 1'b0;
        for (int i = 0; i < 3000 && (rise0 - s_rise) < 100; i++) tick();
        chk("ar_reached_bit100", FB'(rise0 - s_rise), FB'(100));
        reset = 1'b1;
        #1;
        chk("ar_cs_n", FB'(cs_n0), ONE);
        chk("ar_sclk", FB'(sclk0), ONE);
        chk("ar_mosi", FB'(mosi0), ONE);
        chk("ar_busy", FB'(h0.busy), ZERO);
        chk("ar_rx_data", h0.rx_data, ZERO);
        tick();
        reset = 1'b0;
        repeat (2) tick();
        chk("ar_no_done", FB'(done0 - s_done), ZERO);
        run_frame0(W_R, M_R, seen);
        chk("ar_next_done_seen", FB'(seen), ONE);
        chk("ar_next_slave_rx", s_last, W_R);
        chk("ar_next_rx_data", h0.rx_data, M_R);

        // DIV=1 corner, all ones out, miso low
        s_low = low1; s_tog = tog1; s_mhi = mhi1; s_done = done1;
        h1.tx_data = '1; h1.start = 1'b1;
        tick();
        h1.start = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 2000 && !seen; i++) begin
            tick();
            if (h1.done) seen = 1'b1;
        end
        repeat (4) tick();
        chk("d1_done_seen", FB'(seen), ONE);
        chk("d1_rx_data", h1.rx_data, ZERO);
        chk("d1_cs_low_clks", FB'(low1 - s_low), FB'(721));
        chk("d1_sclk_toggles", FB'(tog1 - s_tog), FB'(720));
        chk("d1_mosi_hi_clks", FB'(mhi1 - s_mhi), FB'(721));
        chk("d1_done_count", FB'(done1 - s_done), FB'(1));
        chk("d1_busy_after", FB'(h1.busy), ZERO);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
